// File: rtl/mem_pkg.sv
// Shared types and load-extension helper for the EX->WB memory stage.
package mem_pkg;

    localparam int unsigned MAX_XLEN = 64;

    typedef enum logic [1:0] {
        MSZ_B = 2'd0,
        MSZ_H = 2'd1,
        MSZ_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    // Select the addressed lane of a read word and sign/zero extend it.
    function automatic logic [MAX_XLEN-1:0] ld_extend(
        input logic [MAX_XLEN-1:0] rdata,
        input logic [2:0]          offset,
        input mem_size_e           size,
        input logic                is_unsigned
    );
        logic [31:0]         sh;
        logic [MAX_XLEN-1:0] res;
        sh = 32'(rdata >> {offset, 3'b000});
        case (size)
            MSZ_B:   res = {{(MAX_XLEN-8){~is_unsigned & sh[7]}}, sh[7:0]};
            MSZ_H:   res = {{(MAX_XLEN-16){~is_unsigned & sh[15]}}, sh[15:0]};
            default: res = {{(MAX_XLEN-32){~is_unsigned & sh[31]}}, sh[31:0]};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane placement: word-aligned address, byte enables,
// shifted store data and misalignment flag for one access.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    input  mem_size_e         size,
    output logic [XLEN-1:0]   addr_c,
    output logic [XLEN/8-1:0] be_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic              misalign_c
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);

    logic [OFF_W-1:0] off;
    int unsigned      off_i;
    int unsigned      nbytes;

    always_comb begin
        off    = addr[OFF_W-1:0];
        off_i  = 32'(off);
        nbytes = 4;
        misalign_c = 1'b0;
        case (size)
            MSZ_B: nbytes = 1;
            MSZ_H: begin
                nbytes     = 2;
                misalign_c = addr[0];
            end
            default: begin
                nbytes     = 4;
                misalign_c = (addr[1:0] != 2'b00);
            end
        endcase
        addr_c  = addr & ~XLEN'(NB - 1);
        wdata_c = wdata << {off, 3'b000};
        be_c    = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            be_c[i] = (i >= off_i) && (i < off_i + nbytes);
        end
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// Single-entry registered memory stage between EX and WB: issues a held
// data-port request, waits on dmem_ready with a watchdog, returns to WB.
module mem_stage_pipe
    import mem_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [REG_W-1:0]  rd_in,
    input  logic [XLEN-1:0]   alu_in,
    input  logic [XLEN-1:0]   store_data_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        size_in,
    input  logic              unsigned_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ready,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  rd_out,
    output logic [XLEN-1:0]   result_out,
    output logic              misalign_err,
    output logic              timeout_err
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [OFF_W-1:0]  off_q, off_d;
    mem_size_e         size_q, size_d;
    logic              uns_q, uns_d;
    logic              is_load_q, is_load_d;
    logic              ex_ready_q, ex_ready_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
    logic [NB-1:0]     dmem_be_q, dmem_be_d;
    logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;

    mem_size_e         size_e;
    logic [XLEN-1:0]   al_addr;
    logic [NB-1:0]     al_be;
    logic [XLEN-1:0]   al_wdata;
    logic              al_misalign;
    logic              accept;
    logic              mem_op;

    // Size encoding 3 is treated as a word access.
    always_comb begin
        size_e = (size_in == 2'd3) ? MSZ_W : mem_size_e'(size_in);
    end

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .addr       (alu_in),
        .wdata      (store_data_in),
        .size       (size_e),
        .addr_c     (al_addr),
        .be_c       (al_be),
        .wdata_c    (al_wdata),
        .misalign_c (al_misalign)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        is_load_d    = is_load_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_we_d      = wb_we_q;
        result_d     = result_q;
        misalign_d   = misalign_q;
        timeout_d    = timeout_q;

        accept = ex_valid & ex_ready_q;
        mem_op = mem_read_in | mem_write_in;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    rd_d       = rd_in;
                    off_d      = alu_in[OFF_W-1:0];
                    size_d     = size_e;
                    uns_d      = unsigned_in;
                    is_load_d  = mem_read_in;
                    result_d   = alu_in;
                    misalign_d = 1'b0;
                    timeout_d  = 1'b0;
                    wb_we_d    = 1'b0;
                    if (mem_op && !al_misalign) begin
                        state_d      = ACCESS;
                        cnt_d        = '0;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = mem_write_in;
                        dmem_addr_d  = al_addr;
                        dmem_be_d    = al_be;
                        dmem_wdata_d = al_wdata;
                    end else if (mem_op) begin
                        state_d    = DONE;
                        misalign_d = 1'b1;
                        result_d   = '0;
                    end else begin
                        state_d = DONE;
                        wb_we_d = (rd_in != '0);
                    end
                end
            end
            ACCESS: begin
                // A ready on the final watchdog cycle still completes normally.
                if (dmem_ready) begin
                    state_d    = DONE;
                    dmem_req_d = 1'b0;
                    if (is_load_q) begin
                        result_d = XLEN'(ld_extend(MAX_XLEN'(dmem_rdata), 3'(off_q),
                                                   size_q, uns_q));
                        wb_we_d  = (rd_q != '0);
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d    = DONE;
                    dmem_req_d = 1'b0;
                    timeout_d  = 1'b1;
                    result_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d    = IDLE;
                wb_we_d    = 1'b0;
                misalign_d = 1'b0;
                timeout_d  = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                dmem_req_d = 1'b0;
            end
        endcase

        ex_ready_d = (state_d == IDLE);
        wb_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_q         <= '0;
            off_q        <= '0;
            size_q       <= MSZ_B;
            uns_q        <= 1'b0;
            is_load_q    <= 1'b0;
            ex_ready_q   <= 1'b1;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            result_q     <= '0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            is_load_q    <= is_load_d;
            ex_ready_q   <= ex_ready_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            result_q     <= result_d;
            misalign_q   <= misalign_d;
            timeout_q    <= timeout_d;
        end
    end

    assign ex_ready     = ex_ready_q;
    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_be      = dmem_be_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_we        = wb_we_q;
    assign rd_out       = rd_q;
    assign result_out   = result_q;
    assign misalign_err = misalign_q;
    assign timeout_err  = timeout_q;

endmodule
